uart_fifo_flex: RTL and testbench

Parametrised synchronous FIFO for the UART TX/RX datapaths and the next generation of the UART buffer.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Offers selectable read mode: registered-output or first-word-fall-through (FWFT).
- Single clock domain; sits between the UART serialiser/deserialiser and the bus-side register interface.

---
 rtl/uart_fifo_flex_if.sv | 34 +++
 rtl/uart_fifo_flex.sv | 83 ++++++++
 tb/tb_uart_fifo_flex.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_fifo_flex_if.sv
// Bus-side view of the UART FIFO: request/data inputs plus status outputs.
// The master drives wr/rd/clr_err; the slave (the FIFO) drives data and status.
interface uart_fifo_flex_if #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    // wr/rd are plain per-cycle requests: a request is taken on the rising edge
    // only when the FIFO can honour it (wr && !full, rd && !empty); otherwise it
    // is dropped and latched into the matching sticky error flag.
    logic             wr;
    logic [WIDTH-1:0] wr_data;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] r_data;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, wr_data, rd, clr_err,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  wr, wr_data, rd, clr_err,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_flex.sv
// Synchronous FIFO for the UART datapaths: occupancy count, almost thresholds,
// sticky overflow/underflow, and either registered or fall-through read data.
module uart_fifo_flex #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input logic             clk,
    input logic             rst,
    uart_fifo_flex_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] AF_TH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_TH = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    occ;
    logic             is_full;
    logic             is_empty;
    logic             wr_ok;
    logic             rd_ok;

    // The extra MSB on each pointer distinguishes full from empty when the
    // index bits coincide.
    assign occ      = wr_ptr - rd_ptr;
    assign is_empty = (wr_ptr == rd_ptr);
    assign is_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign wr_ok    = bus.wr && !is_full;
    assign rd_ok    = bus.rd && !is_empty;

    assign bus.count        = occ;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (occ >= AF_TH);
    assign bus.almost_empty = (occ <= AE_TH);

    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            mem[wr_ptr[AW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // A new error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow  <= 1'b0;
            bus.underflow <= 1'b0;
        end else begin
            if (bus.wr && is_full)    bus.overflow <= 1'b1;
            else if (bus.clr_err)     bus.overflow <= 1'b0;
            if (bus.rd && is_empty)   bus.underflow <= 1'b1;
            else if (bus.clr_err)     bus.underflow <= 1'b0;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign bus.r_data = is_empty ? '0 : mem[rd_ptr[AW-1:0]];
    end else begin : g_reg
        logic [WIDTH-1:0] rdata_q;

        always_ff @(posedge clk) begin
            if (rst)        rdata_q <= '0;
            else if (rd_ok) rdata_q <= mem[rd_ptr[AW-1:0]];
        end

        assign bus.r_data = rdata_q;
    end
endmodule

// File: tb/tb_uart_fifo_flex.sv
// Bench for uart_fifo_flex: registered and fall-through instances share one
// stimulus stream and are compared with a queue-based reference model.
module tb_uart_fifo_flex;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;
  localparam int AF_LEVEL = 12;
  localparam int AE_LEVEL = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] wr_data = '0;

  uart_fifo_flex_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if0 ();
  uart_fifo_flex_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) if1 ();

  assign if0.wr = wr;
  assign if0.rd = rd;
  assign if0.clr_err = clr_err;
  assign if0.wr_data = wr_data;
  assign if1.wr = wr;
  assign if1.rd = rd;
  assign if1.clr_err = clr_err;
  assign if1.wr_data = wr_data;

  uart_fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0))
    dut_reg (.clk(clk), .rst(rst), .bus(if0));
  uart_fifo_flex #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1))
    dut_fwft (.clk(clk), .rst(rst), .bus(if1));

  // scoreboard / reference model
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] m_rdata;
  logic             m_ovf;
  logic             m_unf;
  int               errors = 0;
  int               checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic w, input logic rd_v, input logic [WIDTH-1:0] d,
                            input logic c);
    bit was_full;
    bit was_empty;
    if (r) begin
      exp_q.delete();
      m_rdata = '0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      was_full = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (rd_v && !was_empty) m_rdata = exp_q.pop_front();
      if (w && !was_full) exp_q.push_back(d);
      if (w && was_full) m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (rd_v && was_empty) m_unf = 1'b1;
      else if (c) m_unf = 1'b0;
    end
  endtask

  task automatic check_all();
    int n;
    n = exp_q.size();
    check("count", 32'(if0.count), 32'(n));
    check("full", 32'(if0.full), 32'(n == DEPTH));
    check("empty", 32'(if0.empty), 32'(n == 0));
    check("almost_full", 32'(if0.almost_full), 32'(n >= AF_LEVEL));
    check("almost_empty", 32'(if0.almost_empty), 32'(n <= AE_LEVEL));
    check("overflow", 32'(if0.overflow), 32'(m_ovf));
    check("underflow", 32'(if0.underflow), 32'(m_unf));
    check("r_data_reg", 32'(if0.r_data), 32'(m_rdata));
    check("r_data_fwft", 32'(if1.r_data), (n == 0) ? 32'h0 : 32'(exp_q[0]));
    check("fwft_count", 32'(if1.count), 32'(n));
    check("fwft_flags", {30'h0, if1.overflow, if1.underflow}, {30'h0, m_ovf, m_unf});
  endtask

  // driver: one clock cycle with the given request pattern, then check at negedge
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d, input logic c);
    wr = w;
    rd = r;
    wr_data = d;
    clr_err = c;
    @(posedge clk);
    model_edge(rst, w, r, d, c);
    @(negedge clk);
    wr = 1'b0;
    rd = 1'b0;
    clr_err = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, '0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] held;
    @(negedge clk);

    // reset state
    do_reset();
    do_reset();
    check("rst_empty", 32'(if0.empty), 32'd1);
    check("rst_count", 32'(if0.count), 32'd0);
    check("rst_ae", 32'(if0.almost_empty), 32'd1);

    // fill 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, WIDTH'(i), 1'b0);
      check("af_edge", 32'(if0.almost_full), 32'(i >= AF_LEVEL));
    end
    check("fill_full", 32'(if0.full), 32'd1);
    check("fill_count", 32'(if0.count), 32'd16);

    // overflow with 0xAA, sticky, then cleared
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    check("ovf_set", 32'(if0.overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b0);
    check("ovf_hold", 32'(if0.overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("ovf_clr", 32'(if0.overflow), 32'd0);

    // drain in order, each word visible one cycle after rd
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("drain_data", 32'(if0.r_data), 32'(i));
    end
    check("drain_empty", 32'(if0.empty), 32'd1);

    // underflow; clr_err in the same cycle as a new underflow keeps it set
    held = if0.r_data;
    step(1'b0, 1'b1, '0, 1'b0);
    check("unf_set", 32'(if0.underflow), 32'd1);
    check("unf_rdata_hold", 32'(if0.r_data), 32'(held));
    step(1'b0, 1'b1, '0, 1'b1);
    check("unf_set_wins", 32'(if0.underflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);
    check("unf_clr", 32'(if0.underflow), 32'd0);

    // simultaneous wr+rd at count 0, 5 and 16
    step(1'b1, 1'b1, 8'h31, 1'b0);
    check("sim0_count", 32'(if0.count), 32'd1);
    check("sim0_unf", 32'(if0.underflow), 32'd1);
    while (exp_q.size() < 5) step(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    check("sim5_count", 32'(if0.count), 32'd5);
    while (exp_q.size() < DEPTH) step(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
    step(1'b1, 1'b1, 8'h66, 1'b0);
    check("sim16_count", 32'(if0.count), 32'd15);
    check("sim16_ovf", 32'(if0.overflow), 32'd1);
    step(1'b0, 1'b0, '0, 1'b1);

    // random interleaving around the pointer wrap, occupancy kept in 3..10
    while (exp_q.size() > 6) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      logic w;
      logic r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (exp_q.size() <= 3) begin w = 1'b1; r = 1'b0; end
      if (exp_q.size() >= 10) begin w = 1'b0; r = 1'b1; end
      step(w, r, WIDTH'($urandom), 1'b0);
    end
    while (exp_q.size() > 0) step(1'b0, 1'b1, '0, 1'b0);

    // fall-through: write lands on r_data next cycle with no rd, pop returns to 0
    step(1'b1, 1'b0, 8'h5C, 1'b0);
    check("fwft_empty", 32'(if1.empty), 32'd0);
    check("fwft_head", 32'(if1.r_data), 32'h5C);
    step(1'b0, 1'b1, '0, 1'b0);
    check("fwft_pop_empty", 32'(if1.empty), 32'd1);
    check("fwft_pop_zero", 32'(if1.r_data), 32'd0);

    // reset mid-operation with count 7 and a flag set
    step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, WIDTH'($urandom), 1'b0);
    check("pre_rst_count", 32'(if1.count), 32'd7);
    rst = 1'b1;
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    check("rst_mid_count", 32'(if1.count), 32'd0);
    check("rst_mid_empty", 32'(if1.empty), 32'd1);
    check("rst_mid_unf", 32'(if1.underflow), 32'd0);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
